// File: rtl/myo_spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : myo_spi_pkg
// Description : Shared constants for the myo motor-board SPI link. Covers the
//               frame length, the header word, the word-index map of a frame
//               and the responder FSM encoding. The master-side frame builder
//               uses the same definitions.
// Config      : none (see myo_spi_slave for MYO_SLAVE_WATCHDOG_EN)
// Revision    : 1.0 - initial release
// ============================================================================
package myo_spi_pkg;

    localparam int          DEFAULT_FRAME_WORDS = 8;
    localparam logic [15:0] DEFAULT_HEADER      = 16'h8000;

    // Width of the word counter. Wide enough that long frames saturate
    // rather than wrap back onto a valid count.
    localparam int WORD_CNT_W = 8;

    // Word positions within a frame. MISO uses all of them. MOSI uses W_HDR
    // for the header and W_PWM for the pwmRef word.
    localparam logic [WORD_CNT_W-1:0] W_HDR    = 8'd0;
    localparam logic [WORD_CNT_W-1:0] W_POS_HI = 8'd1;
    localparam logic [WORD_CNT_W-1:0] W_POS_LO = 8'd2;
    localparam logic [WORD_CNT_W-1:0] W_VEL    = 8'd3;
    localparam logic [WORD_CNT_W-1:0] W_CUR    = 8'd4;
    localparam logic [WORD_CNT_W-1:0] W_DISP   = 8'd5;
    localparam logic [WORD_CNT_W-1:0] W_S1     = 8'd6;
    localparam logic [WORD_CNT_W-1:0] W_S2     = 8'd7;
    localparam logic [WORD_CNT_W-1:0] W_PWM    = 8'd1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SNAP  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_CHECK = 2'd3
    } state_e;

endpackage : myo_spi_pkg
`default_nettype wire

// File: rtl/myo_spi_sync.sv
`default_nettype none
// ============================================================================
// Module      : myo_spi_sync
// Description : Two-flop synchronizer for one asynchronous pin. A third flop
//               holds the previous synchronized level so that the block can
//               flag rising and falling edges. Edges are reported about two
//               clocks after the pin changes and take effect on the next clock.
// Ports       : clock, reset (async, active-high)
//               pin   - asynchronous input
//               level - synchronized level
//               rise  - 1-cycle pulse on a 0->1 change of level
//               fall  - 1-cycle pulse on a 1->0 change of level
// Revision    : 1.0 - initial release
// ============================================================================
module myo_spi_sync (
    input  logic clock,
    input  logic reset,
    input  logic pin,
    output logic level,
    output logic rise,
    output logic fall
);

    // [0] metastability stage, [1] synchronized level, [2] previous level
    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], pin};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign level = sync_q[1];
    assign rise  = sync_q[1] & ~sync_q[2];
    assign fall  = ~sync_q[1] & sync_q[2];

endmodule : myo_spi_sync
`default_nettype wire

// File: rtl/myo_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : myo_spi_slave
// Description : SPI responder that emulates one myo motor board. It receives
//               the pwmRef frame from the control master and returns a
//               snapshot of the board state taken at frame start. SPI mode is
//               CPOL=0 / CPHA=1, MSB first, 16-bit words, and ss_n stays low
//               for the whole frame. All pins are oversampled in the clock
//               domain.
// Config      : `define MYO_SLAVE_WATCHDOG_EN enables the frame watchdog and
//               the WATCHDOG_CYCLES parameter. When it times out, pwm_ref is
//               forced to 0.
// Ports       : clock, reset (async, active-high)
//               sck, mosi, ss_n      - SPI pins from the master (async)
//               miso, miso_oe        - SPI data back and its tristate enable
//               position_i .. sensor2_i - board state returned to the master
//               pwm_ref, pwm_valid   - last accepted pwmRef and update pulse
//               frame_error          - pulse for a rejected frame
//               frame_count          - number of accepted frames (wraps)
//               timeout              - watchdog expired
// Revision    : 1.0 - initial release
// ============================================================================
module myo_spi_slave
    import myo_spi_pkg::*;
#(
    parameter int          FRAME_WORDS = DEFAULT_FRAME_WORDS,
    parameter logic [15:0] HEADER      = DEFAULT_HEADER
`ifdef MYO_SLAVE_WATCHDOG_EN
   ,parameter int          WATCHDOG_CYCLES = 5_000_000
`endif
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sck,
    input  logic        mosi,
    input  logic        ss_n,
    output logic        miso,
    output logic        miso_oe,
    input  logic [31:0] position_i,
    input  logic [15:0] velocity_i,
    input  logic [15:0] current_i,
    input  logic [15:0] displacement_i,
    input  logic [15:0] sensor1_i,
    input  logic [15:0] sensor2_i,
    output logic [15:0] pwm_ref,
    output logic        pwm_valid,
    output logic        frame_error,
    output logic [15:0] frame_count,
    output logic        timeout
);

    // ------------------------------------------------------------------
    // Pin synchronizers
    // ------------------------------------------------------------------
    logic sck_level, sck_rise, sck_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic ss_level, ss_rise, ss_fall;

    myo_spi_sync u_sync_sck (
        .clock (clock),
        .reset (reset),
        .pin   (sck),
        .level (sck_level),
        .rise  (sck_rise),
        .fall  (sck_fall)
    );

    myo_spi_sync u_sync_mosi (
        .clock (clock),
        .reset (reset),
        .pin   (mosi),
        .level (mosi_level),
        .rise  (mosi_rise),
        .fall  (mosi_fall)
    );

    myo_spi_sync u_sync_ss (
        .clock (clock),
        .reset (reset),
        .pin   (ss_n),
        .level (ss_level),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    // The sck level and the mosi edges are not needed. The FSM leaves
    // SHIFT on the ss_n level, so the ss_n rise pulse is not needed either.
    logic unused_sync;
    assign unused_sync = ^{sck_level, mosi_rise, mosi_fall, ss_rise};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e                 state_q, state_d;
    logic                   armed_q, armed_d;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [WORD_CNT_W-1:0]  word_cnt_q, word_cnt_d;
    logic [15:0]            rx_shift_q, rx_shift_d;
    logic [15:0]            word0_q, word0_d;
    logic [15:0]            word1_q, word1_d;
    logic                   miso_q, miso_d;
    logic                   miso_oe_q, miso_oe_d;
    logic [15:0]            pwm_ref_q, pwm_ref_d;
    logic                   pwm_valid_q, pwm_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic [15:0]            frame_count_q, frame_count_d;

    // Shadow copy of the board state, frozen for the duration of a frame
    logic [31:0]            pos_sh_q, pos_sh_d;
    logic [15:0]            vel_sh_q, vel_sh_d;
    logic [15:0]            cur_sh_q, cur_sh_d;
    logic [15:0]            disp_sh_q, disp_sh_d;
    logic [15:0]            s1_sh_q, s1_sh_d;
    logic [15:0]            s2_sh_q, s2_sh_d;

    logic [15:0]            tx_word;
    logic [15:0]            rx_next;
    logic                   frame_ok;

    // MISO word selected by the current word index; past the frame end: 0
    always_comb begin
        tx_word = 16'h0000;
        case (word_cnt_q)
            W_HDR:    tx_word = HEADER;
            W_POS_HI: tx_word = pos_sh_q[31:16];
            W_POS_LO: tx_word = pos_sh_q[15:0];
            W_VEL:    tx_word = vel_sh_q;
            W_CUR:    tx_word = cur_sh_q;
            W_DISP:   tx_word = disp_sh_q;
            W_S1:     tx_word = s1_sh_q;
            W_S2:     tx_word = s2_sh_q;
            default:  tx_word = 16'h0000;
        endcase
    end

    assign rx_next  = {rx_shift_q[14:0], mosi_level};
    assign frame_ok = (state_q == ST_CHECK)
                   && (word_cnt_q == WORD_CNT_W'(FRAME_WORDS))
                   && (bit_cnt_q == 4'd0)
                   && (word0_q == HEADER);

    always_comb begin
        state_d       = state_q;
        armed_d       = armed_q;
        bit_cnt_d     = bit_cnt_q;
        word_cnt_d    = word_cnt_q;
        rx_shift_d    = rx_shift_q;
        word0_d       = word0_q;
        word1_d       = word1_q;
        miso_d        = miso_q;
        miso_oe_d     = miso_oe_q;
        pwm_ref_d     = pwm_ref_q;
        pwm_valid_d   = 1'b0;
        frame_error_d = 1'b0;
        frame_count_d = frame_count_q;
        pos_sh_d      = pos_sh_q;
        vel_sh_d      = vel_sh_q;
        cur_sh_d      = cur_sh_q;
        disp_sh_d     = disp_sh_q;
        s1_sh_d       = s1_sh_q;
        s2_sh_d       = s2_sh_q;

        // A frame may only start after ss_n has been seen high. This
        // prevents joining a transfer that is already in progress.
        if (ss_level) begin
            armed_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (ss_fall && armed_q) begin
                    state_d = ST_SNAP;
                    armed_d = 1'b0;
                end
            end

            ST_SNAP: begin
                pos_sh_d   = position_i;
                vel_sh_d   = velocity_i;
                cur_sh_d   = current_i;
                disp_sh_d  = displacement_i;
                s1_sh_d    = sensor1_i;
                s2_sh_d    = sensor2_i;
                bit_cnt_d  = 4'd0;
                word_cnt_d = '0;
                rx_shift_d = 16'h0000;
                word0_d    = 16'h0000;
                word1_d    = 16'h0000;
                if (ss_level) begin
                    // ss_n came back before the first bit: count it as a
                    // short frame so that CHECK rejects it.
                    state_d   = ST_CHECK;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end else begin
                    state_d   = ST_SHIFT;
                    miso_d    = HEADER[15];
                    miso_oe_d = 1'b1;
                end
            end

            ST_SHIFT: begin
                if (ss_level) begin
                    state_d   = ST_CHECK;
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                end else begin
                    // CPHA=1: present a bit on the rise and sample on the
                    // fall. bit_cnt is the index of the bit sampled next.
                    if (sck_rise) begin
                        miso_d = tx_word[4'd15 - bit_cnt_q];
                    end
                    if (sck_fall) begin
                        rx_shift_d = rx_next;
                        bit_cnt_d  = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd15) begin
                            if (word_cnt_q == W_HDR) begin
                                word0_d = rx_next;
                            end
                            if (word_cnt_q == W_PWM) begin
                                word1_d = rx_next;
                            end
                            if (word_cnt_q != {WORD_CNT_W{1'b1}}) begin
                                word_cnt_d = word_cnt_q + 1'b1;
                            end
                        end
                    end
                end
            end

            ST_CHECK: begin
                state_d = ST_IDLE;
                if (frame_ok) begin
                    pwm_ref_d     = word1_q;
                    pwm_valid_d   = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                end else begin
                    frame_error_d = 1'b1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            armed_q       <= 1'b0;
            bit_cnt_q     <= 4'd0;
            word_cnt_q    <= '0;
            rx_shift_q    <= 16'h0000;
            word0_q       <= 16'h0000;
            word1_q       <= 16'h0000;
            miso_q        <= 1'b0;
            miso_oe_q     <= 1'b0;
            pwm_ref_q     <= 16'h0000;
            pwm_valid_q   <= 1'b0;
            frame_error_q <= 1'b0;
            frame_count_q <= 16'h0000;
            pos_sh_q      <= 32'h0000_0000;
            vel_sh_q      <= 16'h0000;
            cur_sh_q      <= 16'h0000;
            disp_sh_q     <= 16'h0000;
            s1_sh_q       <= 16'h0000;
            s2_sh_q       <= 16'h0000;
        end else begin
            state_q       <= state_d;
            armed_q       <= armed_d;
            bit_cnt_q     <= bit_cnt_d;
            word_cnt_q    <= word_cnt_d;
            rx_shift_q    <= rx_shift_d;
            word0_q       <= word0_d;
            word1_q       <= word1_d;
            miso_q        <= miso_d;
            miso_oe_q     <= miso_oe_d;
            pwm_ref_q     <= pwm_ref_d;
            pwm_valid_q   <= pwm_valid_d;
            frame_error_q <= frame_error_d;
            frame_count_q <= frame_count_d;
            pos_sh_q      <= pos_sh_d;
            vel_sh_q      <= vel_sh_d;
            cur_sh_q      <= cur_sh_d;
            disp_sh_q     <= disp_sh_d;
            s1_sh_q       <= s1_sh_d;
            s2_sh_q       <= s2_sh_d;
        end
    end

    // ------------------------------------------------------------------
    // Watchdog
    // ------------------------------------------------------------------
`ifdef MYO_SLAVE_WATCHDOG_EN
    logic [31:0] wd_cnt_q, wd_cnt_d;

    // The counter reloads on the same edge that updates pwm_ref. A fresh
    // pwmRef is therefore never masked by a stale timeout.
    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (frame_ok) begin
            wd_cnt_d = 32'(WATCHDOG_CYCLES);
        end else if (wd_cnt_q != 32'd0) begin
            wd_cnt_d = wd_cnt_q - 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wd_cnt_q <= 32'(WATCHDOG_CYCLES);
        end else begin
            wd_cnt_q <= wd_cnt_d;
        end
    end

    assign timeout = (wd_cnt_q == 32'd0);
    // Safe stop: the motor is commanded to zero while the link is dead
    assign pwm_ref = timeout ? 16'h0000 : pwm_ref_q;
`else
    assign timeout = 1'b0;
    assign pwm_ref = pwm_ref_q;
`endif

    assign miso        = miso_q;
    assign miso_oe     = miso_oe_q;
    assign pwm_valid   = pwm_valid_q;
    assign frame_error = frame_error_q;
    assign frame_count = frame_count_q;

endmodule : myo_spi_slave
`default_nettype wire

// File: tb/tb_myo_spi_slave.sv
`default_nettype none
// ============================================================================
// Module      : tb_myo_spi_slave
// Description : Directed testbench for myo_spi_slave. A bit-banged master
//               runs at about 2 MHz SCK against a 50 MHz system clock. A
//               vector table holds frames with their expected results. Reset
//               and watchdog scenarios are written out by hand.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_myo_spi_slave;

    localparam logic [15:0] C_DISP = 16'h0D15;
    localparam logic [15:0] C_S1   = 16'h5151;
    localparam logic [15:0] C_S2   = 16'hA2A2;
    localparam int          C_HALF = 240;   // SCK half period (12 clocks)
`ifdef MYO_SLAVE_WATCHDOG_EN
    localparam bit          C_WD   = 1'b1;
`else
    localparam bit          C_WD   = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        sck, mosi, ss_n;
    logic        miso, miso_oe;
    logic [31:0] position_i;
    logic [15:0] velocity_i, current_i, displacement_i, sensor1_i, sensor2_i;
    logic [15:0] pwm_ref;
    logic        pwm_valid, frame_error;
    logic [15:0] frame_count;
    logic        timeout;

`ifdef MYO_SLAVE_WATCHDOG_EN
    myo_spi_slave #(.WATCHDOG_CYCLES(1000)) dut (
        .clock          (clock),
        .reset          (reset),
        .sck            (sck),
        .mosi           (mosi),
        .ss_n           (ss_n),
        .miso           (miso),
        .miso_oe        (miso_oe),
        .position_i     (position_i),
        .velocity_i     (velocity_i),
        .current_i      (current_i),
        .displacement_i (displacement_i),
        .sensor1_i      (sensor1_i),
        .sensor2_i      (sensor2_i),
        .pwm_ref        (pwm_ref),
        .pwm_valid      (pwm_valid),
        .frame_error    (frame_error),
        .frame_count    (frame_count),
        .timeout        (timeout)
    );
`else
    myo_spi_slave dut (
        .clock          (clock),
        .reset          (reset),
        .sck            (sck),
        .mosi           (mosi),
        .ss_n           (ss_n),
        .miso           (miso),
        .miso_oe        (miso_oe),
        .position_i     (position_i),
        .velocity_i     (velocity_i),
        .current_i      (current_i),
        .displacement_i (displacement_i),
        .sensor1_i      (sensor1_i),
        .sensor2_i      (sensor2_i),
        .pwm_ref        (pwm_ref),
        .pwm_valid      (pwm_valid),
        .frame_error    (frame_error),
        .frame_count    (frame_count),
        .timeout        (timeout)
    );
`endif

    always #10 clock = ~clock;

    typedef struct {
        int          nbits;
        logic [15:0] hdr;
        logic [15:0] pwm;
        logic [31:0] pos;
        logic [15:0] vel;
        logic [15:0] cur;
        bit          chg;
        logic [31:0] pos_mid;
        int          exp_valid;
        int          exp_err;
        logic [15:0] exp_pwm;
        logic [15:0] exp_cnt;
    } vec_t;

    vec_t        vecs[7];
    logic [15:0] tx_words[16];
    logic [15:0] rx_words[16];

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_err = 0;
    int last_valid_cyc = 0;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clock) begin
        cyc = cyc + 1;
        if (pwm_valid === 1'b1) begin
            n_valid = n_valid + 1;
            last_valid_cyc = cyc;
        end
        if (frame_error === 1'b1) begin
            n_err = n_err + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_miso(input int w, input vec_t v);
        case (w)
            0:       return 16'h8000;
            1:       return v.pos[31:16];
            2:       return v.pos[15:0];
            3:       return v.vel;
            4:       return v.cur;
            5:       return C_DISP;
            6:       return C_S1;
            7:       return C_S2;
            default: return 16'h0000;
        endcase
    endfunction

    task automatic send_bits(input int nbits, input bit chg, input logic [31:0] pos_mid);
        for (int i = 0; i < nbits; i++) begin
            int w;
            int b;
            w = i / 16;
            b = 15 - (i % 16);
            if (chg && i == 16) position_i = pos_mid;
            sck  = 1'b1;
            mosi = tx_words[w][b];
            #C_HALF;
            sck  = 1'b0;
            rx_words[w][b] = miso;
            #C_HALF;
        end
    endtask

    task automatic xfer(input int nbits, input bit chg, input logic [31:0] pos_mid);
        ss_n = 1'b0;
        #480;
        check("miso_oe during frame", {31'd0, miso_oe}, 32'd1);
        send_bits(nbits, chg, pos_mid);
        #C_HALF;
        ss_n = 1'b1;
        #1200;
        check("miso_oe after frame", {31'd0, miso_oe}, 32'd0);
    endtask

    initial begin
        vec_t v;
        int   nv;
        int   ne;
        int   tgt;

        //         nbits hdr       pwm       pos           vel       cur       chg  pos_mid       val err exp_pwm   cnt
        vecs[0] = '{128, 16'h8000, 16'h0123, 32'h12345678, 16'hFFFB, 16'h0042, 1'b0, 32'h0,        1, 0, 16'h0123, 16'd1};
        vecs[1] = '{80,  16'h8000, 16'h0456, 32'h00000001, 16'h0002, 16'h0003, 1'b0, 32'h0,        0, 1, 16'h0123, 16'd1};
        vecs[2] = '{128, 16'h7FFF, 16'h0789, 32'h0A0B0C0D, 16'h1111, 16'h2222, 1'b0, 32'h0,        0, 1, 16'h0123, 16'd1};
        vecs[3] = '{144, 16'h8000, 16'h0AAA, 32'hCAFEBABE, 16'h8000, 16'h7FFF, 1'b0, 32'h0,        0, 1, 16'h0123, 16'd1};
        vecs[4] = '{132, 16'h8000, 16'h0BBB, 32'h13579BDF, 16'h0F0F, 16'hF0F0, 1'b0, 32'h0,        0, 1, 16'h0123, 16'd1};
        vecs[5] = '{128, 16'h8000, 16'hFED0, 32'h0000FFFF, 16'h0001, 16'hFFFF, 1'b1, 32'h00010000, 1, 0, 16'hFED0, 16'd2};
        vecs[6] = '{128, 16'h8000, 16'h012C, 32'h00000000, 16'h0000, 16'h0000, 1'b0, 32'h0,        1, 0, 16'h012C, 16'd3};

        reset = 1'b1;
        sck = 1'b0;
        mosi = 1'b0;
        ss_n = 1'b1;
        position_i = 32'h0;
        velocity_i = 16'h0;
        current_i = 16'h0;
        displacement_i = C_DISP;
        sensor1_i = C_S1;
        sensor2_i = C_S2;
        for (int j = 0; j < 16; j++) tx_words[j] = 16'hA5A5;

        #103;
        check("reset miso", {31'd0, miso}, 32'd0);
        check("reset miso_oe", {31'd0, miso_oe}, 32'd0);
        check("reset pwm_ref", {16'd0, pwm_ref}, 32'd0);
        check("reset pwm_valid", {31'd0, pwm_valid}, 32'd0);
        check("reset frame_error", {31'd0, frame_error}, 32'd0);
        check("reset frame_count", {16'd0, frame_count}, 32'd0);
        check("reset timeout", {31'd0, timeout}, 32'd0);
        reset = 1'b0;
        #200;

        for (int k = 0; k < 7; k++) begin
            logic [15:0] pwm_eff;
            v = vecs[k];
            position_i  = v.pos;
            velocity_i  = v.vel;
            current_i   = v.cur;
            tx_words[0] = v.hdr;
            tx_words[1] = v.pwm;
            nv = n_valid;
            ne = n_err;
            #200;
            xfer(v.nbits, v.chg, v.pos_mid);
            // With the watchdog on, each rejected frame lasts longer than the
            // timeout, so the output is already forced to zero.
            pwm_eff = (C_WD && v.exp_valid == 0) ? 16'h0000 : v.exp_pwm;
            check($sformatf("v%0d pwm_valid pulses", k), n_valid - nv, v.exp_valid);
            check($sformatf("v%0d frame_error pulses", k), n_err - ne, v.exp_err);
            check($sformatf("v%0d pwm_ref", k), {16'd0, pwm_ref}, {16'd0, pwm_eff});
            check($sformatf("v%0d frame_count", k), {16'd0, frame_count}, {16'd0, v.exp_cnt});
            check($sformatf("v%0d timeout", k), {31'd0, timeout},
                  {31'd0, (C_WD && v.exp_valid == 0)});
            for (int w = 0; w < v.nbits / 16; w++) begin
                check($sformatf("v%0d miso word %0d", k, w), {16'd0, rx_words[w]},
                      {16'd0, exp_miso(w, v)});
            end
        end

`ifdef MYO_SLAVE_WATCHDOG_EN
        // Watchdog: pwm_ref=300 stays until 1000 clocks pass with no frame
        tgt = last_valid_cyc + 990;
        while (cyc < tgt) @(negedge clock);
        check("wd before expiry timeout", {31'd0, timeout}, 32'd0);
        check("wd before expiry pwm_ref", {16'd0, pwm_ref}, 32'd300);
        tgt = last_valid_cyc + 1010;
        while (cyc < tgt) @(negedge clock);
        check("wd expired timeout", {31'd0, timeout}, 32'd1);
        check("wd expired pwm_ref", {16'd0, pwm_ref}, 32'd0);
        #3;
        tx_words[0] = 16'h8000;
        tx_words[1] = 16'h0055;
        xfer(128, 1'b0, 32'h0);
        check("wd recovered timeout", {31'd0, timeout}, 32'd0);
        check("wd recovered pwm_ref", {16'd0, pwm_ref}, 32'h0055);
        #7;
`endif

        // Reset in the middle of a frame with ss_n held low
        tx_words[0] = 16'h8000;
        tx_words[1] = 16'h0BAD;
        ss_n = 1'b0;
        #480;
        send_bits(40, 1'b0, 32'h0);
        reset = 1'b1;
        #100;
        reset = 1'b0;
        #200;
        check("mid reset pwm_ref", {16'd0, pwm_ref}, 32'd0);
        check("mid reset frame_count", {16'd0, frame_count}, 32'd0);
        check("mid reset miso_oe", {31'd0, miso_oe}, 32'd0);
        nv = n_valid;
        ne = n_err;
        send_bits(128, 1'b0, 32'h0);
        check("unarmed frame miso_oe", {31'd0, miso_oe}, 32'd0);
        #C_HALF;
        ss_n = 1'b1;
        #1200;
        check("unarmed frame pwm_valid", n_valid - nv, 32'd0);
        check("unarmed frame frame_error", n_err - ne, 32'd0);
        check("unarmed frame frame_count", {16'd0, frame_count}, 32'd0);
        tx_words[1] = 16'h0777;
        nv = n_valid;
        xfer(128, 1'b0, 32'h0);
        check("post reset pwm_valid", n_valid - nv, 32'd1);
        check("post reset frame_count", {16'd0, frame_count}, 32'd1);
        check("post reset pwm_ref", {16'd0, pwm_ref}, 32'h0777);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_myo_spi_slave
`default_nettype wire
